sipo_rx: RTL and testbench

Serial-in/parallel-out receiver: the receive end of the parallel-load shift-register link (MSB-first serial stream with load and done framing). It reassembles one WIDTH-bit word per frame and presents it as a parallel word with a one-cycle valid strobe. It cross-checks the transmitter's done flag against its own bit count and flags framing errors. It shares the transmitter's clock and sits directly on the sout/load/done wires.

---
 rtl/sipo_rx_if.sv | 23 ++
 rtl/sipo_rx.sv | 117 +++++++++++
 tb/tb_sipo_rx.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sipo_rx_if.sv
// Serial link between the parallel-load shift-register transmitter and sipo_rx.
// The master modport is the transmitter/consumer side and the slave modport is the receiver.
interface sipo_rx_if #(
    parameter int WIDTH = 32
);
    logic             load;
    logic             sin;
    logic             done;
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic             err;
    logic             busy;

    modport master (
        output load, sin, done,
        input  dout, valid, err, busy
    );

    modport slave (
        input  load, sin, done,
        output dout, valid, err, busy
    );
endinterface

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver. It reassembles one MSB-first word per load-framed
// burst and checks the transmitter's done flag against its own sample count.
module sipo_rx #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    sipo_rx_if.slave  link
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    localparam logic [7:0] WIDTH_CNT = 8'(WIDTH);

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_err;

    state_t           w_nxt_state;
    logic [7:0]       w_nxt_cnt;
    logic [WIDTH-1:0] w_nxt_sr;
    logic [WIDTH-1:0] w_nxt_dout;
    logic             w_nxt_valid;
    logic             w_nxt_err;
    logic [7:0]       w_sample_n;
    logic [WIDTH-1:0] w_shifted;

    // w_sample_n is the number of the sample taken at this edge while in SHIFT.
    assign w_sample_n = r_cnt + 8'd1;
    assign w_shifted  = {r_sr[WIDTH-2:0], link.sin};

    // NOTE: every output of this block gets a default before any branch, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_sr    = r_sr;
        w_nxt_dout  = r_dout;
        w_nxt_valid = 1'b0;
        w_nxt_err   = 1'b0;

        if (link.load) begin
            // A load always (re)starts a frame, silently dropping any frame in progress.
            w_nxt_state = ST_ARMED;
            w_nxt_cnt   = 8'd0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    // sin and done carry the transmitter's zero-fill here and are ignored.
                end
                ST_ARMED: begin
                    if (link.done) begin
                        w_nxt_state = ST_IDLE;
                        w_nxt_err   = 1'b1;
                    end else begin
                        w_nxt_sr    = w_shifted;
                        w_nxt_cnt   = 8'd1;
                        w_nxt_state = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_sample_n < WIDTH_CNT) begin
                        if (link.done) begin
                            w_nxt_state = ST_IDLE;
                            w_nxt_err   = 1'b1;
                        end else begin
                            w_nxt_sr  = w_shifted;
                            w_nxt_cnt = w_sample_n;
                        end
                    end else begin
                        w_nxt_state = ST_IDLE;
                        if (link.done) begin
                            w_nxt_dout  = w_shifted;
                            w_nxt_valid = 1'b1;
                        end else begin
                            w_nxt_err   = 1'b1;
                        end
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_sr    <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_sr    <= w_nxt_sr;
            r_dout  <= w_nxt_dout;
            r_valid <= w_nxt_valid;
            r_err   <= w_nxt_err;
        end
    end

    assign link.dout  = r_dout;
    assign link.valid = r_valid;
    assign link.err   = r_err;
    assign link.busy  = (r_state != ST_IDLE);
endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: a 32-bit and an 8-bit receiver driven by a behavioural transmitter,
// with expected outputs derived from frame-level rules.
module tb_sipo_rx;
    localparam int K_GOOD  = 0;
    localparam int K_ABORT = 1;
    localparam int K_EARLY = 2;
    localparam int K_MISS  = 3;

    logic clk = 1'b0;
    logic rst_n;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_dout32 = '0;
    logic [31:0] exp_dout8  = '0;

    always #5 clk = ~clk;

    sipo_rx_if #(.WIDTH(32)) b32 ();
    sipo_rx_if #(.WIDTH(8))  b8 ();

    sipo_rx #(.WIDTH(32)) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (b32)
    );

    sipo_rx #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (b8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
        n_vec++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive the selected link; the other link is held quiet.
    task automatic drive(bit s8, bit ld, bit si, bit dn);
        if (s8) begin
            b8.load = ld;  b8.sin = si;  b8.done = dn;
            b32.load = 1'b0; b32.sin = 1'b0; b32.done = 1'b0;
        end else begin
            b32.load = ld; b32.sin = si; b32.done = dn;
            b8.load = 1'b0;  b8.sin = 1'b0;  b8.done = 1'b0;
        end
    endtask

    task automatic check_outs(bit s8, string tag, bit ev, bit ee, bit eb);
        if (s8) begin
            check({tag, "_valid8"}, 32'(b8.valid), 32'(ev));
            check({tag, "_err8"},   32'(b8.err),   32'(ee));
            check({tag, "_busy8"},  32'(b8.busy),  32'(eb));
            check({tag, "_dout8"},  {24'd0, b8.dout}, exp_dout8);
        end else begin
            check({tag, "_valid32"}, 32'(b32.valid), 32'(ev));
            check({tag, "_err32"},   32'(b32.err),   32'(ee));
            check({tag, "_busy32"},  32'(b32.busy),  32'(eb));
            check({tag, "_dout32"},  b32.dout,       exp_dout32);
        end
    endtask

    // Idle cycles carry random sin/done, standing in for the transmitter's zero-fill.
    task automatic idle(bit s8, int n);
        for (int i = 0; i < n; i++) begin
            drive(s8, 1'b0, 1'($urandom), 1'($urandom));
            tick();
            check_outs(s8, "idle", 1'b0, 1'b0, 1'b0);
        end
    endtask

    // One transmitted frame: nload load cycles, then MSB-first samples with done high on
    // the last. ABORT stops after pos samples (caller starts the next frame at once);
    // EARLY raises done at sample pos; MISS withholds done on the last sample.
    task automatic frame(bit s8, logic [31:0] word, int nload, int kind, int pos);
        int w;
        bit si;
        bit dn;
        w = s8 ? 8 : 32;
        for (int i = 0; i < nload; i++) begin
            drive(s8, 1'b1, 1'($urandom), 1'($urandom));
            tick();
            check_outs(s8, "load", 1'b0, 1'b0, 1'b1);
        end
        for (int k = 1; k <= w; k++) begin
            if (kind == K_ABORT && k > pos) return;
            si = word[w-k];
            dn = (k == w);
            if (kind == K_EARLY && k == pos) dn = 1'b1;
            if (kind == K_MISS && k == w) dn = 1'b0;
            drive(s8, 1'b0, si, dn);
            tick();
            if (kind == K_EARLY && k == pos) begin
                check_outs(s8, "early", 1'b0, 1'b1, 1'b0);
                return;
            end
            if (k < w) begin
                check_outs(s8, "shift", 1'b0, 1'b0, 1'b1);
            end else if (kind == K_MISS) begin
                check_outs(s8, "miss", 1'b0, 1'b1, 1'b0);
            end else begin
                if (s8) exp_dout8 = word & 32'h0000_00FF;
                else    exp_dout32 = word;
                check_outs(s8, "frame", 1'b1, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        int kind;
        int pos;
        bit s8;

        // Reset state of both receivers.
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check_outs(1'b0, "reset", 1'b0, 1'b0, 1'b0);
        check_outs(1'b1, "reset", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle(1'b0, 3);

        // Single frame.
        frame(1'b0, 32'hA5A5_0F0F, 1, K_GOOD, 0);
        idle(1'b0, 4);

        // Reset mid-SHIFT with load toggling; no valid may follow.
        frame(1'b0, $urandom, 1, K_ABORT, 12);
        rst_n = 1'b0;
        exp_dout32 = '0;
        exp_dout8  = '0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, (i % 2) == 0, 1'($urandom), 1'($urandom));
            tick();
            check_outs(1'b0, "rst_mid", 1'b0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        idle(1'b0, 6);
        idle(1'b1, 2);

        // Back-to-back frames, then the same with a 3-cycle load on the second word.
        frame(1'b0, 32'hFFFF_FFFF, 1, K_GOOD, 0);
        frame(1'b0, 32'h0000_0001, 1, K_GOOD, 0);
        frame(1'b0, 32'h8000_0000, 1, K_GOOD, 0);
        frame(1'b0, 32'hFFFF_FFFF, 1, K_GOOD, 0);
        frame(1'b0, 32'h0000_0001, 3, K_GOOD, 0);
        frame(1'b0, 32'h8000_0000, 1, K_GOOD, 0);
        idle(1'b0, 2);

        // Abort after 10 samples, then a full word.
        frame(1'b0, 32'h1234_5678, 1, K_ABORT, 10);
        frame(1'b0, 32'hCAFE_BABE, 1, K_GOOD, 0);
        idle(1'b0, 3);

        // Framing errors: premature done at sample 20 and at the ARMED sample, missing done.
        frame(1'b0, 32'h0BAD_F00D, 1, K_EARLY, 20);
        idle(1'b0, 3);
        frame(1'b0, 32'h7777_1111, 1, K_EARLY, 1);
        idle(1'b0, 2);
        frame(1'b0, 32'h1357_9BDF, 1, K_MISS, 0);
        idle(1'b0, 3);

        // 8-bit receiver.
        frame(1'b1, 32'h0000_003C, 1, K_GOOD, 0);
        idle(1'b1, 2);
        frame(1'b1, 32'h0000_00C3, 1, K_GOOD, 0);
        frame(1'b1, 32'h0000_005A, 2, K_GOOD, 0);
        frame(1'b1, 32'h0000_00E1, 1, K_EARLY, 7);
        idle(1'b1, 2);

        // Randomized frames: 25 on the 32-bit receiver, then 15 on the 8-bit one.
        for (int f = 0; f < 40; f++) begin
            s8   = (f >= 25);
            kind = $urandom_range(0, 3);
            pos  = s8 ? $urandom_range(1, 7) : $urandom_range(1, 31);
            frame(s8, $urandom, $urandom_range(1, 3), kind, pos);
            if (kind != K_ABORT) idle(s8, $urandom_range(0, 3));
        end
        frame(1'b1, $urandom, 1, K_GOOD, 0);
        idle(1'b1, 2);
        frame(1'b0, $urandom, 1, K_GOOD, 0);
        idle(1'b0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
